// File: rtl/issue_buf_ctrl_if.sv
// Handshake/pointer bundle between IF, the instruction buffer RAM, ID and
// the buffer controller.
interface issue_buf_ctrl_if #(
    parameter int unsigned PTR_W = 4
);
    logic             flush_i;
    logic             in_valid1_i;
    logic             in_valid2_i;
    logic             issue_i;
    logic             issue_mode_i;
    logic             br_taken_i;
    logic             br_slot_i;

    logic             wr_en1_o;
    logic             wr_en2_o;
    logic [PTR_W-1:0] wr_ptr1_o;
    logic [PTR_W-1:0] wr_ptr2_o;
    logic [PTR_W-1:0] rd_ptr1_o;
    logic [PTR_W-1:0] rd_ptr2_o;
    logic [PTR_W:0]   count_o;
    logic             issue_ok_o;
    logic             dual_ok_o;
    logic             full_o;
    logic             overflow_o;
    logic [1:0]       state_o;

    modport master (
        output flush_i, in_valid1_i, in_valid2_i, issue_i, issue_mode_i,
               br_taken_i, br_slot_i,
        input  wr_en1_o, wr_en2_o, wr_ptr1_o, wr_ptr2_o, rd_ptr1_o, rd_ptr2_o,
               count_o, issue_ok_o, dual_ok_o, full_o, overflow_o, state_o
    );

    modport slave (
        input  flush_i, in_valid1_i, in_valid2_i, issue_i, issue_mode_i,
               br_taken_i, br_slot_i,
        output wr_en1_o, wr_en2_o, wr_ptr1_o, wr_ptr2_o, rd_ptr1_o, rd_ptr2_o,
               count_o, issue_ok_o, dual_ok_o, full_o, overflow_o, state_o
    );
endinterface

// File: rtl/issue_buf_ctrl.sv
// Pointer/occupancy controller for the 2-in/2-out IF->ID instruction buffer,
// including branch delay-slot sequencing.
module issue_buf_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    issue_buf_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        WAIT_DS = 2'b01,
        DS_HOLD = 2'b10
    } state_e;

    localparam logic [PTR_W:0]   FULL_TH = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             full;
    logic [1:0]       n_i;
    logic [1:0]       n_w;
    logic [PTR_W:0]   rem;
    logic             br_act, br_clear, br_keep, br_wait;
    logic             drop1, drop2;
    logic             wr1, wr2;

    assign full = count_q > FULL_TH;

    always_comb begin
        n_i = 2'd0;
        if (bus.issue_i && count_q != '0) begin
            if (bus.issue_mode_i && count_q >= (PTR_W+1)'(2) && state_q == RUN)
                n_i = 2'd2;
            else
                n_i = 2'd1;
        end
    end

    assign rem      = count_q - (PTR_W+1)'(n_i);
    assign br_act   = bus.br_taken_i && n_i != 2'd0 && state_q == RUN;
    assign br_clear = br_act && !bus.br_slot_i && n_i == 2'd2;
    assign br_keep  = br_act && !br_clear && rem != '0;
    assign br_wait  = br_act && !br_clear && rem == '0;

    // Slot 1 survives a pending delay slot (br_wait / WAIT_DS); slot 2 never does.
    assign drop1 = bus.flush_i || br_clear || br_keep || state_q == DS_HOLD;
    assign drop2 = drop1 || br_wait || state_q == WAIT_DS;

    assign wr1   = rst && bus.in_valid1_i && !full && !bus.flush_i && !drop1;
    assign wr2   = wr1 && bus.in_valid2_i && !drop2;
    assign n_w   = {1'b0, wr1} + {1'b0, wr2};
    assign ovf_d = bus.in_valid1_i && full && !drop1;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush_i || br_clear) begin
            state_d = RUN;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (br_keep) begin
            state_d = DS_HOLD;
            head_d  = head_q + PTR_W'(n_i);
            tail_d  = head_q + PTR_W'(n_i) + PTR_ONE;
            count_d = (PTR_W+1)'(1);
        end else if (br_wait) begin
            // Buffer drains completely here, so the new head equals the tail.
            head_d = head_q + PTR_W'(n_i);
            if (wr1) begin
                state_d = DS_HOLD;
                tail_d  = tail_q + PTR_ONE;
                count_d = (PTR_W+1)'(1);
            end else begin
                state_d = WAIT_DS;
                count_d = '0;
            end
        end else begin
            case (state_q)
                WAIT_DS: begin
                    if (wr1) begin
                        state_d = DS_HOLD;
                        tail_d  = tail_q + PTR_ONE;
                        count_d = (PTR_W+1)'(1);
                    end
                end
                DS_HOLD: begin
                    if (n_i != 2'd0) begin
                        state_d = RUN;
                        head_d  = head_q + PTR_ONE;
                        count_d = '0;
                    end
                end
                default: begin
                    head_d  = head_q + PTR_W'(n_i);
                    tail_d  = tail_q + PTR_W'(n_w);
                    count_d = count_q + (PTR_W+1)'(n_w) - (PTR_W+1)'(n_i);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wr_en1_o   = wr1;
    assign bus.wr_en2_o   = wr2;
    assign bus.wr_ptr1_o  = tail_q;
    assign bus.wr_ptr2_o  = tail_q + PTR_ONE;
    assign bus.rd_ptr1_o  = head_q;
    assign bus.rd_ptr2_o  = head_q + PTR_ONE;
    assign bus.count_o    = count_q;
    assign bus.issue_ok_o = count_q != '0 && (state_q == RUN || state_q == DS_HOLD);
    assign bus.dual_ok_o  = count_q >= (PTR_W+1)'(2) && state_q == RUN;
    assign bus.full_o     = full;
    assign bus.overflow_o = ovf_q;
    assign bus.state_o    = state_q;
endmodule
